// File: rtl/fast_pulse_pacer_if.sv
// fast_pulse_pacer_if
//   Groups the event/status signals of fast_pulse_pacer. All signals live in
//   the fast clock domain (clk_fast).
//   in_pulse      event strobe into the pacer (one event per high cycle)
//   clr_overflow  single-cycle clear of the sticky overflow flag
//   out_pulse     paced event strobe toward the toggle synchronizer
//   pending       count of accepted events not yet emitted
//   overflow      sticky drop indicator
//   busy          pacer has pending events or a gap in progress
//   CNT_W must match the CNT_W of the fast_pulse_pacer it connects to.
interface fast_pulse_pacer_if #(
   parameter int CNT_W = 4
) ();
   logic             in_pulse;
   logic             clr_overflow;
   logic             out_pulse;
   logic [CNT_W-1:0] pending;
   logic             overflow;
   logic             busy;

   // Event source / status consumer side.
   modport master (
      output in_pulse,
      output clr_overflow,
      input  out_pulse,
      input  pending,
      input  overflow,
      input  busy
   );

   // Pacer side.
   modport slave (
      input  in_pulse,
      input  clr_overflow,
      output out_pulse,
      output pending,
      output overflow,
      output busy
   );
endinterface

// File: rtl/fast_pulse_pacer.sv
// fast_pulse_pacer
//   Re-emits single-cycle event pulses one at a time, at least GAP clk_fast
//   cycles apart, so that no two source toggles of the downstream
//   fast-to-slow synchronizer land in one slow sampling window. Events that
//   arrive while the pending counter is saturated (and no issue happens that
//   cycle) are dropped and flagged by a sticky overflow bit.
//   The parent must guarantee GAP * T_fast >= 3 * T_slow.
// Ports
//   clk_fast  fast-domain clock, posedge
//   rst_fast  synchronous active-high reset
//   bus       fast_pulse_pacer_if.slave: in_pulse, clr_overflow (in);
//             out_pulse, pending, overflow, busy (out)
module fast_pulse_pacer #(
   parameter int GAP   = 8,
   parameter int CNT_W = 4
) (
   input  logic               clk_fast,
   input  logic               rst_fast,
   fast_pulse_pacer_if.slave  bus
);
   localparam int               GAP_W    = $clog2(GAP) + 1;
   localparam logic [CNT_W-1:0] PEND_MAX = '1;

   typedef enum logic {
      IDLE    = 1'b0,
      SPACING = 1'b1
   } state_t;

   logic [GAP_W-1:0] gap_cnt_reg, gap_cnt_next;
   logic [CNT_W-1:0] pending_reg, pending_next;
   logic             out_pulse_reg, out_pulse_next;
   logic             overflow_reg, overflow_next;
   logic             drop;
   state_t           state;

   // The effective state is fully encoded by the gap counter.
   always_comb begin
      state = (gap_cnt_reg == '0) ? IDLE : SPACING;
   end

   always_comb begin
      gap_cnt_next   = gap_cnt_reg;
      pending_next   = pending_reg;
      out_pulse_next = 1'b0;
      drop           = 1'b0;
      case (state)
         IDLE: begin
            if ((pending_reg != '0) || bus.in_pulse) begin
               out_pulse_next = 1'b1;
               gap_cnt_next   = GAP_W'(GAP - 1);
               // pending + in_pulse - 1: an arriving pulse either replaces
               // the issued one (count holds) or bypasses an empty counter.
               if (!bus.in_pulse) begin
                  pending_next = pending_reg - CNT_W'(1);
               end
            end
         end
         SPACING: begin
            gap_cnt_next = gap_cnt_reg - GAP_W'(1);
            if (bus.in_pulse) begin
               if (pending_reg == PEND_MAX) begin
                  drop = 1'b1;
               end else begin
                  pending_next = pending_reg + CNT_W'(1);
               end
            end
         end
         default: begin
            gap_cnt_next = '0;
         end
      endcase

      // A drop in the same cycle as a clear must leave the flag set.
      if (drop) begin
         overflow_next = 1'b1;
      end else if (bus.clr_overflow) begin
         overflow_next = 1'b0;
      end else begin
         overflow_next = overflow_reg;
      end
   end

   always_ff @(posedge clk_fast) begin
      if (rst_fast) begin
         gap_cnt_reg   <= '0;
         pending_reg   <= '0;
         out_pulse_reg <= 1'b0;
         overflow_reg  <= 1'b0;
      end else begin
         gap_cnt_reg   <= gap_cnt_next;
         pending_reg   <= pending_next;
         out_pulse_reg <= out_pulse_next;
         overflow_reg  <= overflow_next;
      end
   end

   assign bus.out_pulse = out_pulse_reg;
   assign bus.pending   = pending_reg;
   assign bus.overflow  = overflow_reg;
   assign bus.busy      = (pending_reg != '0) || (gap_cnt_reg != '0);
endmodule

// File: tb/tb_fast_pulse_pacer.sv
// tb_fast_pulse_pacer
//   Two pacers share clock, reset and stimulus: dut_a (GAP=4, CNT_W=3) and
//   dut_b (GAP=1, CNT_W=2, passthrough). A timestamp/count model predicts
//   every output each cycle; directed sequences pin literal values.
module tb_fast_pulse_pacer;
   localparam int GAP_A = 4;
   localparam int CW_A  = 3;
   localparam int GAP_B = 1;
   localparam int CW_B  = 2;

   typedef struct packed {
      int   pend;
      int   last;   // cycle index of the most recent issue
      logic out;
      logic ovf;
      logic busy;
   } mstate_t;

   logic    clk_fast = 1'b0;
   logic    rst_fast;
   int      n_checks = 0;
   int      n_fail   = 0;
   int      cyc      = 0;
   bit      check_en = 1'b0;
   mstate_t ma, mb;

   fast_pulse_pacer_if #(.CNT_W(CW_A)) ia ();
   fast_pulse_pacer_if #(.CNT_W(CW_B)) ib ();

   fast_pulse_pacer #(.GAP(GAP_A), .CNT_W(CW_A)) dut_a (
      .clk_fast (clk_fast),
      .rst_fast (rst_fast),
      .bus      (ia)
   );

   fast_pulse_pacer #(.GAP(GAP_B), .CNT_W(CW_B)) dut_b (
      .clk_fast (clk_fast),
      .rst_fast (rst_fast),
      .bus      (ib)
   );

   always #5 clk_fast = ~clk_fast;

   // Behavioural model: an issue may happen at cycle c only if c is at least
   // GAP cycles after the previous issue; outputs appear one cycle later.
   function automatic mstate_t model_next(mstate_t m, int gap, int maxp,
                                          logic in_p, logic clr, logic rst, int c);
      mstate_t n;
      logic    drop;
      n    = m;
      drop = 1'b0;
      if (rst) begin
         n.pend = 0;
         n.last = -1000000;
         n.out  = 1'b0;
         n.ovf  = 1'b0;
      end else begin
         if ((c >= m.last + gap) && ((m.pend > 0) || in_p)) begin
            n.out  = 1'b1;
            n.last = c;
            n.pend = (m.pend == 0) ? 0 : m.pend + (in_p ? 1 : 0) - 1;
         end else begin
            n.out = 1'b0;
            if (in_p) begin
               if (m.pend >= maxp) drop = 1'b1;
               else                n.pend = m.pend + 1;
            end
         end
         if (drop)     n.ovf = 1'b1;
         else if (clr) n.ovf = 1'b0;
      end
      n.busy = (n.pend != 0) || (c + 1 < n.last + gap);
      return n;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
      end
   endtask

   task automatic step(input logic in_p, input logic clr, input logic rst);
      ia.in_pulse     = in_p;
      ib.in_pulse     = in_p;
      ia.clr_overflow = clr;
      ib.clr_overflow = clr;
      rst_fast        = rst;
      @(posedge clk_fast);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
   endtask

   // Model advance on every active edge.
   initial begin
      ma = '{pend: 0, last: -1000000, out: 1'b0, ovf: 1'b0, busy: 1'b0};
      mb = ma;
      forever begin
         @(posedge clk_fast);
         ma = model_next(ma, GAP_A, (1 << CW_A) - 1, ia.in_pulse, ia.clr_overflow, rst_fast, cyc);
         mb = model_next(mb, GAP_B, (1 << CW_B) - 1, ib.in_pulse, ib.clr_overflow, rst_fast, cyc);
         cyc++;
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   initial begin
      forever begin
         @(negedge clk_fast);
         if (check_en) begin
            chk("a_out",  int'(ia.out_pulse), int'(ma.out));
            chk("a_pend", int'(ia.pending),   ma.pend);
            chk("a_ovf",  int'(ia.overflow),  int'(ma.ovf));
            chk("a_busy", int'(ia.busy),      int'(ma.busy));
            chk("b_out",  int'(ib.out_pulse), int'(mb.out));
            chk("b_pend", int'(ib.pending),   mb.pend);
            chk("b_ovf",  int'(ib.overflow),  int'(mb.ovf));
            chk("b_busy", int'(ib.busy),      int'(mb.busy));
         end
      end
   end

   initial begin
      int  p_in;
      bit  found;
      ia.in_pulse = 1'b0; ib.in_pulse = 1'b0;
      ia.clr_overflow = 1'b0; ib.clr_overflow = 1'b0;
      rst_fast = 1'b1;

      // Reset values
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1);
      check_en = 1'b1;
      chk("rst_out",  int'(ia.out_pulse), 0);
      chk("rst_pend", int'(ia.pending),   0);
      chk("rst_ovf",  int'(ia.overflow),  0);
      chk("rst_busy", int'(ia.busy),      0);
      idle(3);

      // Single event: out at cycle 1 only, busy cycles 1..GAP-1
      for (int t = 0; t < 6; t++) begin
         step(t == 0, 1'b0, 1'b0);
         chk("single_out",  int'(ia.out_pulse), (t + 1 == 1) ? 1 : 0);
         chk("single_busy", int'(ia.busy),      (t + 1 <= 3) ? 1 : 0);
         chk("single_pend", int'(ia.pending),   0);
      end
      idle(10);

      // Burst at cycles 0,1,2 -> out at 1,5,9
      for (int t = 0; t < 11; t++) begin
         step(t <= 2, 1'b0, 1'b0);
         chk("burst_out", int'(ia.out_pulse), (t + 1 == 1 || t + 1 == 5 || t + 1 == 9) ? 1 : 0);
         if (t + 1 == 2) chk("burst_pend2", int'(ia.pending), 1);
         if (t + 1 == 3) chk("burst_pend3", int'(ia.pending), 2);
         if (t + 1 == 5) chk("burst_pend5", int'(ia.pending), 1);
         if (t + 1 == 9) chk("burst_pend9", int'(ia.pending), 0);
      end
      idle(10);

      // Saturation, drop, set-vs-clear, accept-at-full on an issue cycle
      for (int t = 0; t < 14; t++) begin
         step(t <= 12, t == 11, 1'b0);
         if (t + 1 == 10) chk("sat_pend10", int'(ia.pending),  7);
         if (t + 1 == 10) chk("sat_ovf10",  int'(ia.overflow), 0);
         if (t + 1 == 11) chk("drop_ovf11", int'(ia.overflow), 1);
         if (t + 1 == 12) chk("setclr_ovf", int'(ia.overflow), 1);
         if (t + 1 == 13) chk("full_issue_pend", int'(ia.pending), 7);
         if (t + 1 == 14) chk("sticky_ovf", int'(ia.overflow), 1);
      end

      // Reset mid-burst once pending reaches 5
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         if (ia.pending == 3'd5) found = 1'b1;
         else step(1'b0, 1'b0, 1'b0);
      end
      chk("reach_pend5", int'(found), 1);
      step(1'b0, 1'b0, 1'b1);
      chk("midrst_pend", int'(ia.pending),   0);
      chk("midrst_ovf",  int'(ia.overflow),  0);
      chk("midrst_out",  int'(ia.out_pulse), 0);
      for (int t = 0; t < 12; t++) begin
         step(1'b0, 1'b0, 1'b0);
         chk("midrst_quiet", int'(ia.out_pulse), 0);
      end

      // GAP=1 passthrough: 10 input cycles -> 10 following output cycles
      chk("pass_pre", int'(ib.out_pulse), 0);
      for (int t = 0; t < 12; t++) begin
         step(t < 10, 1'b0, 1'b0);
         chk("pass_out",  int'(ib.out_pulse), (t < 10) ? 1 : 0);
         chk("pass_pend", int'(ib.pending),   0);
      end
      idle(20);

      // Randomized traffic at several densities, checked by the model
      for (int seg = 0; seg < 4; seg++) begin
         p_in = (seg == 0) ? 15 : (seg == 1) ? 40 : (seg == 2) ? 85 : 60;
         for (int i = 0; i < 750; i++) begin
            step($urandom_range(99) < p_in,
                 $urandom_range(99) < 4,
                 $urandom_range(999) < 3);
         end
      end
      idle(40);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
